// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction memory port, decode-side control and IF/ID outputs.
// master = fetch stage, slave = the surrounding pipeline/memory.
interface instruction_fetch_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        halted;
    logic        fault;
    logic [31:0] fetch_count;

    modport master (
        output imem_addr, if_id_valid, if_id_pc, if_id_instr, halted, fault, fetch_count,
        input  imem_instr, stall, redirect_valid, redirect_target
    );

    modport slave (
        input  imem_addr, if_id_valid, if_id_pc, if_id_instr, halted, fault, fetch_count,
        output imem_instr, stall, redirect_valid, redirect_target
    );
endinterface

// File: rtl/instruction_fetch.sv
// PC and fetch stage: drives imem_addr from the PC, fills the IF/ID register, and
// handles stalls, redirects, misaligned-target faults and EBREAK halt.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input logic               clk,
    input logic               reset,
    instruction_fetch_if.master bus
);
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    typedef enum logic [1:0] {BOOT, RUN, HALT, FAULT} state_e;

    state_e      state_q,  state_d;
    logic [31:0] pc_q,     pc_d;
    logic        valid_q,  valid_d;
    logic [31:0] ipc_q,    ipc_d;
    logic [31:0] instr_q,  instr_d;
    logic        halted_q, halted_d;
    logic        fault_q,  fault_d;
    logic [31:0] count_q,  count_d;

    assign bus.imem_addr   = pc_q;
    assign bus.if_id_valid = valid_q;
    assign bus.if_id_pc    = ipc_q;
    assign bus.if_id_instr = instr_q;
    assign bus.halted      = halted_q;
    assign bus.fault       = fault_q;
    assign bus.fetch_count = count_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        ipc_d    = ipc_q;
        instr_d  = instr_q;
        halted_d = halted_q;
        fault_d  = fault_q;
        count_d  = count_q;
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (bus.redirect_valid) begin
                    valid_d = 1'b0;
                    if (bus.redirect_target[1:0] == 2'b00) begin
                        pc_d    = bus.redirect_target;
                        ipc_d   = '0;
                        instr_d = NOP_INSTR;
                    end else begin
                        state_d = FAULT;
                        fault_d = 1'b1;
                    end
                end else if (!bus.stall) begin
                    instr_d = bus.imem_instr;
                    ipc_d   = pc_q;
                    valid_d = 1'b1;
                    count_d = count_q + 32'd1;
                    // EBREAK is delivered downstream; halted rises one edge later in HALT.
                    if (bus.imem_instr == EBREAK) state_d = HALT;
                    else                          pc_d    = pc_q + 32'd4;
                end
            end
            HALT: begin
                valid_d  = 1'b0;
                halted_d = 1'b1;
            end
            FAULT: valid_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= BOOT;
            pc_q     <= RESET_PC;
            valid_q  <= 1'b0;
            ipc_q    <= '0;
            instr_q  <= NOP_INSTR;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            ipc_q    <= ipc_d;
            instr_q  <= instr_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
            count_q  <= count_d;
        end
    end
endmodule
